// File: rtl/neuron_cfg_regs.sv
// SPI-fed bank of 8-bit neuron configuration registers with auto-incrementing burst writes.
// Optional burst readback on din is compiled in with NEURON_CFG_READBACK_EN.
module neuron_cfg_regs #(
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ss,
    input  logic [7:0]               byte_in,
    input  logic                     byte_done,
    output logic [7:0]               din,
    output logic [8*(2**ADDR_W)-1:0] cfg_out,
    output logic                     cfg_update,
    output logic [ADDR_W-1:0]        cfg_wr_addr,
    output logic                     cmd_err
);
    localparam int NREGS = 2**ADDR_W;

`ifdef NEURON_CFG_READBACK_EN
    localparam bit READBACK_EN = 1'b1;
`else
    localparam bit READBACK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WR_DATA, RD_DATA, DISCARD} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [7:0]        din_reg, din_next;
    logic              upd_reg, upd_next;
    logic              err_reg, err_next;
    logic              wr_en;

    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [6:0]        cmd_rsvd;
    logic              cmd_bad;

    assign cmd_addr = byte_in[ADDR_W-1:0];
    assign cmd_rsvd = byte_in[6:0] >> ADDR_W;
    // Reads count as invalid commands when the readback path is not built.
    assign cmd_bad  = (cmd_rsvd != 7'd0) || (!byte_in[7] && !READBACK_EN);
    assign addr_inc = addr_reg + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (ss) begin
            state_next = IDLE;
        end else if (byte_done && state_reg == IDLE) begin
            if (cmd_bad) begin
                state_next = DISCARD;
            end else if (byte_in[7]) begin
                state_next = WR_DATA;
            end else begin
                state_next = RD_DATA;
            end
        end
    end

    always_comb begin
        addr_next    = addr_reg;
        din_next     = din_reg;
        wr_addr_next = wr_addr_reg;
        upd_next     = 1'b0;
        err_next     = 1'b0;
        wr_en        = 1'b0;
        if (ss) begin
            // Frame end (or ss/byte_done collision): drop the byte, rewind the pointer.
            addr_next = '0;
            din_next  = 8'h00;
        end else if (byte_done) begin
            case (state_reg)
                IDLE: begin
                    if (cmd_bad) begin
                        err_next = 1'b1;
                    end else begin
                        addr_next = cmd_addr;
                        if (!byte_in[7]) begin
                            din_next = cfg_out[{cmd_addr, 3'b000} +: 8];
                        end
                    end
                end
                WR_DATA: begin
                    wr_en        = 1'b1;
                    upd_next     = 1'b1;
                    wr_addr_next = addr_reg;
                    addr_next    = addr_inc;
                end
                RD_DATA: begin
                    addr_next = addr_inc;
                    din_next  = cfg_out[{addr_inc, 3'b000} +: 8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg    <= '0;
            din_reg     <= 8'h00;
            wr_addr_reg <= '0;
            upd_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            addr_reg    <= addr_next;
            din_reg     <= din_next;
            wr_addr_reg <= wr_addr_next;
            upd_reg     <= upd_next;
            err_reg     <= err_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_bank
            logic [7:0] cell_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cell_reg <= 8'h00;
                end else if (wr_en && addr_reg == ADDR_W'(gi)) begin
                    cell_reg <= byte_in;
                end
            end
            assign cfg_out[8*gi +: 8] = cell_reg;
        end
    endgenerate

    assign din         = din_reg;
    assign cfg_update  = upd_reg;
    assign cfg_wr_addr = wr_addr_reg;
    assign cmd_err     = err_reg;

endmodule
